// File: rtl/fp_add_arbiter_if.sv
// Requester, shared-adder and response signals of fp_add_arbiter.
// master is the arbiter's view; slave is the surrounding logic's view.
interface fp_add_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [9:0] req0_a;
  logic [9:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [9:0] req1_a;
  logic [9:0] req1_b;
  logic [9:0] add_a;
  logic [9:0] add_b;
  logic [9:0] add_s;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [9:0] rsp_s;
  logic [7:0] sat_cnt;

  modport master (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_s, rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b,
    output rsp_valid, rsp_id, rsp_s, sat_cnt
  );

  modport slave (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_s, rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b,
    input  rsp_valid, rsp_id, rsp_s, sat_cnt
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin front end for one shared ADD_LAT-cycle FP adder; one operation in flight.
// Accept -> rsp_valid ADD_LAT+1 edges later; result held under rsp_ready backpressure.
module fp_add_arbiter #(
  parameter int ADD_LAT = 1  // legal 1..4
) (
  input logic              clk,
  input logic              rst_n,
  fp_add_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic       last_grant;
  logic [9:0] add_a_q;
  logic [9:0] add_b_q;
  logic [9:0] rsp_s_q;
  logic       rsp_id_q;
  logic [7:0] sat_cnt_q;
  logic       gnt0;
  logic       gnt1;
  logic       accept;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = BUSY;
      BUSY:    if (capture)       state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Grants are only offered in IDLE; rst_n gating keeps ready low while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign accept  = gnt0 | gnt1;
  assign capture = (state == BUSY) && (lat_cnt == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      last_grant <= 1'b1;
      add_a_q    <= '0;
      add_b_q    <= '0;
      rsp_s_q    <= '0;
      rsp_id_q   <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      if (accept) begin
        add_a_q    <= gnt1 ? bus.req1_a : bus.req0_a;
        add_b_q    <= gnt1 ? bus.req1_b : bus.req0_b;
        rsp_id_q   <= gnt1;
        last_grant <= gnt1;
        lat_cnt    <= 3'(ADD_LAT);
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      // The adder already saturates, so an all-ones sum marks an overflowed result.
      if (capture) begin
        rsp_s_q <= bus.add_s;
        if (bus.add_s == 10'h3FF && sat_cnt_q != 8'hFF) sat_cnt_q <= sat_cnt_q + 8'd1;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_s      = rsp_s_q;
  assign bus.sat_cnt    = sat_cnt_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus a randomized run against a timestamp model.
// Two instances, ADD_LAT=1 and ADD_LAT=4, each fed by a behavioural FP adder.
module tb_fp_add_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  fp_add_arbiter_if if1 ();
  fp_add_arbiter_if if4 ();

  fp_add_arbiter #(.ADD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  fp_add_arbiter #(.ADD_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));

  // Value = (64 + man) * 2^exp; sum renormalised, truncated, saturated to 3FF.
  function automatic logic [9:0] fp_add(input logic [9:0] x, input logic [9:0] y);
    longint sx;
    longint sy;
    longint sum;
    int     e;
    sx  = longint'(64 + int'(x[5:0])) << x[9:6];
    sy  = longint'(64 + int'(y[5:0])) << y[9:6];
    sum = sx + sy;
    e   = 0;
    while ((sum >> e) > 127) e++;
    if (e > 15) return 10'h3FF;
    return {4'(e), 6'((sum >> e) - 64)};
  endfunction

  logic [9:0] p4 [0:2];
  assign if1.add_s = fp_add(if1.add_a, if1.add_b);
  always @(posedge clk) begin
    p4[0] <= fp_add(if4.add_a, if4.add_b);
    p4[1] <= p4[0];
    p4[2] <= p4[1];
  end
  assign if4.add_s = p4[2];

  task automatic idle_inputs();
    if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
    if1.req0_a = '0; if1.req0_b = '0; if1.req1_a = '0; if1.req1_b = '0;
    if1.rsp_ready = 1'b1;
    if4.req0_valid = 1'b0; if4.req1_valid = 1'b0;
    if4.req0_a = '0; if4.req0_b = '0; if4.req1_a = '0; if4.req1_b = '0;
    if4.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if1.req0_valid = 1'b1; if1.req1_valid = 1'b1;
    if1.req0_a = 10'h155; if1.req0_b = 10'h2AA;
    if4.req0_valid = 1'b1; if4.req1_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.rsp_id} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.rsp_id});
    else pass_cnt++;
    chk_cnt++;
    if ({if1.add_a, if1.add_b, if1.rsp_s, if1.sat_cnt} !== 38'd0)
      $display("FAIL reset_data: got %h want 0", {if1.add_a, if1.add_b, if1.rsp_s, if1.sat_cnt});
    else pass_cnt++;
    chk_cnt++;
    if ({if4.req0_ready, if4.req1_ready, if4.rsp_valid, if4.add_a, if4.sat_cnt} !== 21'd0)
      $display("FAIL reset_lat4: got %h want 0", {if4.req0_ready, if4.req1_ready, if4.rsp_valid, if4.add_a, if4.sat_cnt});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.req1_ready} !== 2'b10)
      $display("FAIL reset_first_grant: got %b want 10", {if1.req0_ready, if1.req1_ready});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    if1.req0_valid = 1'b1; if1.req0_a = 10'h040; if1.req0_b = 10'h040;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.req1_ready} !== 2'b10)
      $display("FAIL basic_grant: got %b want 10", {if1.req0_ready, if1.req1_ready});
    else pass_cnt++;
    @(negedge clk);
    if1.req0_valid = 1'b0;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.rsp_valid, if1.add_a, if1.add_b} !== {2'b00, 10'h040, 10'h040})
      $display("FAIL basic_busy: got %h want %h", {if1.req0_ready, if1.rsp_valid, if1.add_a, if1.add_b}, {2'b00, 10'h040, 10'h040});
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({if1.rsp_valid, if1.rsp_id, if1.rsp_s} !== {2'b10, 10'h080})
      $display("FAIL basic_rsp: got %h want %h", {if1.rsp_valid, if1.rsp_id, if1.rsp_s}, {2'b10, 10'h080});
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (if1.rsp_valid !== 1'b0) $display("FAIL basic_rsp_drop: got %b want 0", if1.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [9:0] exp_s [0:1];
    do_reset();
    if1.req0_valid = 1'b1; if1.req0_a = 10'h041; if1.req0_b = 10'h042;
    if1.req1_valid = 1'b1; if1.req1_a = 10'h0C3; if1.req1_b = 10'h101;
    exp_s[0] = fp_add(10'h041, 10'h042);
    exp_s[1] = fp_add(10'h0C3, 10'h101);
    // Accepts every 3 cycles, alternating 0,1,0,1 starting with requester 0.
    for (int c = 0; c < 12; c++) begin
      logic e0, e1, ev, eid;
      #1;
      eid = 1'((c / 3) % 2);
      e0  = (c % 3 == 0) && !eid;
      e1  = (c % 3 == 0) && eid;
      ev  = (c % 3 == 2);
      chk_cnt++;
      if ({if1.req0_ready, if1.req1_ready, if1.rsp_valid} !== {e0, e1, ev})
        $display("FAIL rr_hs c%0d: got %b want %b", c, {if1.req0_ready, if1.req1_ready, if1.rsp_valid}, {e0, e1, ev});
      else pass_cnt++;
      if (ev) begin
        chk_cnt++;
        if ({if1.rsp_id, if1.rsp_s} !== {eid, exp_s[eid]})
          $display("FAIL rr_rsp c%0d: got %h want %h", c, {if1.rsp_id, if1.rsp_s}, {eid, exp_s[eid]});
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    if1.req1_valid = 1'b1; if1.req1_a = 10'h3C0; if1.req1_b = 10'h3C0;
    #1;
    chk_cnt++;
    if (if1.sat_cnt !== 8'd0) $display("FAIL sat_init: got %0d want 0", if1.sat_cnt);
    else pass_cnt++;
    for (int n = 1; n <= 300; n++) begin
      logic [7:0] esat;
      esat = (n > 255) ? 8'd255 : 8'(n);
      chk_cnt++;
      if ({if1.req0_ready, if1.req1_ready} !== 2'b01)
        $display("FAIL sat_grant op%0d: got %b want 01", n, {if1.req0_ready, if1.req1_ready});
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk); #1;
      chk_cnt++;
      if ({if1.rsp_valid, if1.rsp_id, if1.rsp_s, if1.sat_cnt} !== {2'b11, 10'h3FF, esat})
        $display("FAIL sat_rsp op%0d: got %h want %h", n, {if1.rsp_valid, if1.rsp_id, if1.rsp_s, if1.sat_cnt}, {2'b11, 10'h3FF, esat});
      else pass_cnt++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] es;
    do_reset();
    es = fp_add(10'h2A5, 10'h1F3);
    if1.req0_valid = 1'b1; if1.req0_a = 10'h2A5; if1.req0_b = 10'h1F3;
    if1.rsp_ready = 1'b0;
    #1;
    chk_cnt++;
    if (if1.req0_ready !== 1'b1) $display("FAIL bp_grant: got %b want 1", if1.req0_ready);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      if1.req0_valid = 1'($urandom_range(0, 1));
      if1.req1_valid = 1'($urandom_range(0, 1));
      if1.req0_a = 10'($urandom);
      if1.req1_a = 10'($urandom);
      #1;
      chk_cnt++;
      if ({if1.rsp_valid, if1.req0_ready, if1.req1_ready, if1.rsp_id, if1.rsp_s} !== {4'b1000, es})
        $display("FAIL bp_hold h%0d: got %h want %h", h, {if1.rsp_valid, if1.req0_ready, if1.req1_ready, if1.rsp_id, if1.rsp_s}, {4'b1000, es});
      else pass_cnt++;
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    if1.req0_valid = 1'b1; if1.req1_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({if1.rsp_valid, if1.req0_ready, if1.req1_ready} !== 3'b100)
      $display("FAIL bp_release: got %b want 100", {if1.rsp_valid, if1.req0_ready, if1.req1_ready});
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if ({if1.rsp_valid, if1.req0_ready, if1.req1_ready} !== 3'b001)
      $display("FAIL bp_idle: got %b want 001", {if1.rsp_valid, if1.req0_ready, if1.req1_ready});
    else pass_cnt++;
  endtask

  task automatic test_lat4();
    logic [9:0] es;
    do_reset();
    es = fp_add(10'h155, 10'h0AA);
    if4.req0_valid = 1'b1; if4.req0_a = 10'h155; if4.req0_b = 10'h0AA;
    #1;
    chk_cnt++;
    if ({if4.req0_ready, if4.req1_ready} !== 2'b10)
      $display("FAIL lat4_grant: got %b want 10", {if4.req0_ready, if4.req1_ready});
    else pass_cnt++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if4.req0_valid = 1'($urandom_range(0, 1));
      if4.req1_valid = 1'($urandom_range(0, 1));
      if4.req0_a = 10'($urandom); if4.req0_b = 10'($urandom);
      if4.req1_a = 10'($urandom); if4.req1_b = 10'($urandom);
      #1;
      chk_cnt++;
      if ({if4.rsp_valid, if4.req0_ready, if4.req1_ready, if4.add_a, if4.add_b} !== {3'b000, 10'h155, 10'h0AA})
        $display("FAIL lat4_busy c%0d: got %h want %h", c, {if4.rsp_valid, if4.req0_ready, if4.req1_ready, if4.add_a, if4.add_b}, {3'b000, 10'h155, 10'h0AA});
      else pass_cnt++;
    end
    @(negedge clk);
    if4.req0_valid = 1'b0; if4.req1_valid = 1'b0;
    #1;
    chk_cnt++;
    if ({if4.rsp_valid, if4.rsp_id, if4.rsp_s} !== {2'b10, es})
      $display("FAIL lat4_rsp: got %h want %h", {if4.rsp_valid, if4.rsp_id, if4.rsp_s}, {2'b10, es});
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (if4.rsp_valid !== 1'b0) $display("FAIL lat4_rsp_drop: got %b want 0", if4.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    do_reset();
    if1.req0_valid = 1'b1; if1.req0_a = 10'h0F0; if1.req0_b = 10'h3C0;
    @(negedge clk);
    if1.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    if1.req0_valid = 1'b1; if1.req1_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.rsp_id, if1.add_a, if1.add_b, if1.rsp_s, if1.sat_cnt} !== 42'd0)
      $display("FAIL rstbusy_outputs: got %h want 0", {if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.rsp_id, if1.add_a, if1.add_b, if1.rsp_s, if1.sat_cnt});
    else pass_cnt++;
    @(negedge clk);
    if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++;
      if (if1.rsp_valid !== 1'b0) $display("FAIL rstbusy_no_rsp c%0d: got %b want 0", c, if1.rsp_valid);
      else pass_cnt++;
      @(negedge clk);
    end
    if1.req0_valid = 1'b1; if1.req1_valid = 1'b1;
    #1;
    chk_cnt++;
    if ({if1.req0_ready, if1.req1_ready} !== 2'b10)
      $display("FAIL rstbusy_regrant: got %b want 10", {if1.req0_ready, if1.req1_ready});
    else pass_cnt++;
  endtask

  // Model: at most one op pending; response visible from accept+2 until the rsp_ready cycle.
  task automatic test_random();
    bit         pend   = 1'b0;
    int         rsp_at = 0;
    bit         lastg  = 1'b1;
    int         sat    = 0;
    logic       exp_id = 1'b0;
    logic [9:0] exp_s  = '0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic v0, v1, rr, e0, e1, ev;
      logic [9:0] a0, b0, a1, b1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 5) == 0) ? 10'h3C0 : 10'($urandom);
      b0 = 10'($urandom);
      a1 = ($urandom_range(0, 5) == 0) ? 10'h3C0 : 10'($urandom);
      b1 = ($urandom_range(0, 5) == 0) ? 10'h3C0 : 10'($urandom);
      if1.req0_valid = v0; if1.req0_a = a0; if1.req0_b = b0;
      if1.req1_valid = v1; if1.req1_a = a1; if1.req1_b = b1;
      if1.rsp_ready  = rr;
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!pend) begin
        if (v0 && v1) begin
          e0 = lastg;
          e1 = !lastg;
        end else begin
          e0 = v0;
          e1 = v1;
        end
      end
      ev = pend && (i >= rsp_at);
      if (ev && i == rsp_at && exp_s == 10'h3FF && sat < 255) sat++;
      chk_cnt++;
      if ({if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.sat_cnt} !== {e0, e1, ev, 8'(sat)})
        $display("FAIL rand_hs i%0d: got %h want %h", i, {if1.req0_ready, if1.req1_ready, if1.rsp_valid, if1.sat_cnt}, {e0, e1, ev, 8'(sat)});
      else pass_cnt++;
      if (ev) begin
        chk_cnt++;
        if ({if1.rsp_id, if1.rsp_s} !== {exp_id, exp_s})
          $display("FAIL rand_rsp i%0d: got %h want %h", i, {if1.rsp_id, if1.rsp_s}, {exp_id, exp_s});
        else pass_cnt++;
      end
      if (e0 || e1) begin
        pend   = 1'b1;
        rsp_at = i + 2;
        exp_id = e1;
        exp_s  = e1 ? fp_add(a1, b1) : fp_add(a0, b0);
        lastg  = e1;
      end else if (ev && rr) begin
        pend = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_saturation();
    test_backpressure();
    test_lat4();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
